// File: rtl/axi_lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// axi_lite_reg_slave_if : AXI4-Lite AW/W/B/AR/R channel bundle for one slave port
// Revision: 1.0
// ============================================================================
interface axi_lite_reg_slave_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] s_awaddr;
   logic              s_awvalid;
   logic              s_awready;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic              s_wvalid;
   logic              s_wready;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;
   logic [ADDR_W-1:0] s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic [31:0]       s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rvalid;
   logic              s_rready;

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
             s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
             s_arready, s_rdata, s_rresp, s_rvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// axi_lite_reg_slave : AXI4-Lite register block, NUM_REGS-1 RW words + RO status
// Revision: 1.0
// ============================================================================
module axi_lite_reg_slave #(
   parameter int ADDR_W   = 12,
   parameter int NUM_REGS = 8
) (
   input  wire logic           clk,
   input  wire logic           reset,
   axi_lite_reg_slave_if.slave s,
   input  wire logic [31:0]    status_in,
   output logic [31:0]         ctrl_out
);
   localparam int         IDX_W    = ADDR_W - 2;
   localparam int         NUM_RW   = NUM_REGS - 1;
   localparam logic [1:0] C_OKAY   = 2'b00;
   localparam logic [1:0] C_SLVERR = 2'b10;

   logic              aw_full_q, aw_full_d;
   logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
   logic              w_full_q,  w_full_d;
   logic [31:0]       wdata_q,   wdata_d;
   logic [3:0]        wstrb_q,   wstrb_d;
   logic              bvalid_q,  bvalid_d;
   logic [1:0]        bresp_q,   bresp_d;
   logic              rvalid_q,  rvalid_d;
   logic [31:0]       rdata_q,   rdata_d;
   logic [1:0]        rresp_q,   rresp_d;
   logic [31:0]       regs_q [NUM_RW];
   logic [31:0]       regs_d [NUM_RW];

   logic              awready, wready, arready;
   logic              aw_hs, w_hs, ar_hs, commit, write_ok;
   logic [IDX_W-1:0]  ar_idx;
   logic [31:0]       rd_reg;
   logic              unused_addr_lsbs;

   assign awready  = !aw_full_q && !bvalid_q;
   assign wready   = !w_full_q && !bvalid_q;
   assign arready  = !rvalid_q;
   assign aw_hs    = s.s_awvalid && awready;
   assign w_hs     = s.s_wvalid && wready;
   assign ar_hs    = s.s_arvalid && arready;
   assign commit   = aw_full_q && w_full_q;
   assign write_ok = 32'(aw_idx_q) < 32'(NUM_RW);
   assign ar_idx   = s.s_araddr[ADDR_W-1:2];

   // Byte offset within a word carries no meaning for 32-bit registers.
   assign unused_addr_lsbs = ^{s.s_awaddr[1:0], s.s_araddr[1:0]};

   assign s.s_awready = awready;
   assign s.s_wready  = wready;
   assign s.s_arready = arready;
   assign s.s_bvalid  = bvalid_q;
   assign s.s_bresp   = bresp_q;
   assign s.s_rvalid  = rvalid_q;
   assign s.s_rdata   = rdata_q;
   assign s.s_rresp   = rresp_q;
   assign ctrl_out    = regs_q[0];

   always_comb begin
      rd_reg = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (ar_idx == IDX_W'(i)) begin
            rd_reg = regs_q[i];
         end
      end
   end

   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      regs_d    = regs_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = s.s_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = s.s_wdata;
         wstrb_d  = s.s_wstrb;
      end
      if (bvalid_q && s.s_bready) begin
         bvalid_d = 1'b0;
      end

      // Both halves captured: commit now; readiness is blocked until B drains.
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = write_ok ? C_OKAY : C_SLVERR;
         for (int i = 0; i < NUM_RW; i++) begin
            if (write_ok && aw_idx_q == IDX_W'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (wstrb_q[b]) begin
                     regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                  end
               end
            end
         end
      end

      if (rvalid_q && s.s_rready) begin
         rvalid_d = 1'b0;
      end
      // Read data comes from the current register state, so a coincident commit is not visible.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (32'(ar_idx) >= 32'(NUM_REGS)) begin
            rdata_d = '0;
            rresp_d = C_SLVERR;
         end else if (32'(ar_idx) == 32'(NUM_RW)) begin
            rdata_d = status_in;
            rresp_d = C_OKAY;
         end else begin
            rdata_d = rd_reg;
            rresp_d = C_OKAY;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= C_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= C_OKAY;
         for (int i = 0; i < NUM_RW; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_reg_slave : directed stimulus with B/R scoreboard queues
// Revision: 1.0
// ============================================================================
module tb_axi_lite_reg_slave;
   localparam int ADDR_W   = 12;
   localparam int NUM_REGS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] status_in;
   logic [31:0] ctrl_out;
   int          total = 0;
   int          bad   = 0;
   logic [1:0]  exp_b_q [$];
   logic [33:0] exp_r_q [$];

   axi_lite_reg_slave_if #(.ADDR_W(ADDR_W)) bus ();

   axi_lite_reg_slave #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
      .clk       (clk),
      .reset     (reset),
      .s         (bus.slave),
      .status_in (status_in),
      .ctrl_out  (ctrl_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a response is consumed on the cycle its handshake completes.
   always @(negedge clk) begin
      if (!reset && bus.s_bvalid && bus.s_bready) begin
         if (exp_b_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_b: got bresp=%0d expected no response", bus.s_bresp);
         end else begin
            chk("bresp", 64'(bus.s_bresp), 64'(exp_b_q.pop_front()));
         end
      end
      if (!reset && bus.s_rvalid && bus.s_rready) begin
         if (exp_r_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_r: got rdata=0x%0h expected no response", bus.s_rdata);
         end else begin
            chk("rdata_rresp", 64'({bus.s_rdata, bus.s_rresp}), 64'(exp_r_q.pop_front()));
         end
      end
   end

   task automatic do_aw(input logic [ADDR_W-1:0] a);
      bus.s_awaddr  = a;
      bus.s_awvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.s_awready) begin
            @(posedge clk); #1;
            bus.s_awvalid = 1'b0;
            return;
         end
      end
      bus.s_awvalid = 1'b0;
      total++; bad++;
      $display("FAIL aw_timeout: got awready=0 for 20 cycles expected 1");
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] st);
      bus.s_wdata  = d;
      bus.s_wstrb  = st;
      bus.s_wvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.s_wready) begin
            @(posedge clk); #1;
            bus.s_wvalid = 1'b0;
            return;
         end
      end
      bus.s_wvalid = 1'b0;
      total++; bad++;
      $display("FAIL w_timeout: got wready=0 for 20 cycles expected 1");
   endtask

   task automatic do_ar(input logic [ADDR_W-1:0] a);
      bus.s_araddr  = a;
      bus.s_arvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.s_arready) begin
            @(posedge clk); #1;
            bus.s_arvalid = 1'b0;
            return;
         end
      end
      bus.s_arvalid = 1'b0;
      total++; bad++;
      $display("FAIL ar_timeout: got arready=0 for 20 cycles expected 1");
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_bvalid"},  64'(bus.s_bvalid),  64'd0);
      chk({tag, "_rvalid"},  64'(bus.s_rvalid),  64'd0);
      chk({tag, "_awready"}, 64'(bus.s_awready), 64'd1);
      chk({tag, "_wready"},  64'(bus.s_wready),  64'd1);
      chk({tag, "_arready"}, 64'(bus.s_arready), 64'd1);
      chk({tag, "_bresp"},   64'(bus.s_bresp),   64'd0);
      chk({tag, "_rresp"},   64'(bus.s_rresp),   64'd0);
      chk({tag, "_rdata"},   64'(bus.s_rdata),   64'd0);
      chk({tag, "_ctrl"},    64'(ctrl_out),      64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      status_in = 32'h0;
      bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
      bus.s_wdata = '0;  bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
      bus.s_bready = 1'b1;
      bus.s_araddr = '0; bus.s_arvalid = 1'b0;
      bus.s_rready = 1'b1;
      idle(3);
      chk_reset_outputs("rst");
      reset = 1'b0;
      idle(1);

      // AW and W together; B one edge after the handshake.
      exp_b_q.push_back(2'b00);
      fork
         do_aw(12'h000);
         do_w(32'hDEADBEEF, 4'hF);
      join
      chk("t1_bvalid_early", 64'(bus.s_bvalid), 64'd0);
      idle(1);
      chk("t1_bvalid", 64'(bus.s_bvalid), 64'd1);
      chk("t1_ctrl_out", 64'(ctrl_out), 64'hDEADBEEF);
      idle(2);
      exp_r_q.push_back({32'hDEADBEEF, 2'b00});
      do_ar(12'h000);
      idle(2);

      // W leads AW by two cycles, partial strobes over zero.
      exp_b_q.push_back(2'b00);
      do_w(32'h11223344, 4'b0101);
      chk("t2_wready_held", 64'(bus.s_wready), 64'd0);
      idle(1);
      do_aw(12'h004);
      chk("t2_bvalid_early", 64'(bus.s_bvalid), 64'd0);
      idle(1);
      chk("t2_bvalid", 64'(bus.s_bvalid), 64'd1);
      idle(2);
      exp_r_q.push_back({32'h00220044, 2'b00});
      do_ar(12'h004);
      exp_r_q.push_back({32'h00220044, 2'b00});
      do_ar(12'h007);
      idle(2);

      // Status word is read-only; out-of-range read errors.
      status_in = 32'hA5A5_0001;
      exp_b_q.push_back(2'b10);
      fork
         do_aw(12'h01C);
         do_w(32'hFFFFFFFF, 4'hF);
      join
      idle(3);
      chk("t3_ctrl_kept", 64'(ctrl_out), 64'hDEADBEEF);
      exp_r_q.push_back({32'hA5A5_0001, 2'b00});
      do_ar(12'h01C);
      exp_r_q.push_back({32'h0, 2'b10});
      do_ar(12'h020);
      idle(2);

      // B back-pressure.
      bus.s_bready = 1'b0;
      exp_b_q.push_back(2'b00);
      fork
         do_aw(12'h00C);
         do_w(32'h0000_0001, 4'hF);
      join
      idle(1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_bvalid_hold", 64'(bus.s_bvalid), 64'd1);
         chk("t4_bresp_hold", 64'(bus.s_bresp), 64'd0);
         chk("t4_awready_low", 64'(bus.s_awready), 64'd0);
         chk("t4_wready_low", 64'(bus.s_wready), 64'd0);
      end
      @(posedge clk); #1;
      bus.s_bready = 1'b1;
      idle(2);

      // R back-pressure.
      bus.s_rready = 1'b0;
      exp_r_q.push_back({32'h0000_0001, 2'b00});
      do_ar(12'h00C);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_rvalid_hold", 64'(bus.s_rvalid), 64'd1);
         chk("t4_rdata_hold", 64'(bus.s_rdata), 64'h1);
         chk("t4_arready_low", 64'(bus.s_arready), 64'd0);
      end
      @(posedge clk); #1;
      bus.s_rready = 1'b1;
      idle(2);

      // Read on the commit edge sees the old value.
      exp_b_q.push_back(2'b00);
      exp_r_q.push_back({32'h0, 2'b00});
      fork
         do_aw(12'h008);
         do_w(32'h0000_0055, 4'hF);
      join
      do_ar(12'h008);
      idle(2);
      exp_r_q.push_back({32'h0000_0055, 2'b00});
      do_ar(12'h008);
      idle(2);

      // Reset with AW captured and R pending.
      bus.s_rready = 1'b0;
      do_aw(12'h004);
      do_ar(12'h000);
      chk("t6_rvalid_pre", 64'(bus.s_rvalid), 64'd1);
      chk("t6_awready_pre", 64'(bus.s_awready), 64'd0);
      reset = 1'b1;
      #1;
      chk_reset_outputs("t6_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      bus.s_rready = 1'b1;
      do_w(32'h1234_5678, 4'hF);
      idle(5);
      chk("t6_no_bvalid", 64'(bus.s_bvalid), 64'd0);
      chk("t6_no_rvalid", 64'(bus.s_rvalid), 64'd0);
      exp_r_q.push_back({32'h0, 2'b00});
      do_ar(12'h004);
      idle(3);

      chk("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
      chk("r_queue_empty", 64'(exp_r_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI4-Lite responder (slave end) of the NoC: terminates the AW/W/B and AR/R channels that the interconnect drives toward a peripheral.
- Implements NUM_REGS 32-bit registers: indices 0..NUM_REGS-2 are read/write control; index NUM_REGS-1 is a read-only hardware status word.
- Register 0 is exported as ctrl_out to drive local dashcam peripheral logic.
- Sits directly on one NoC slave port.

Parameters:
- ADDR_W, 12, byte-address width of the AW and AR ports.
- NUM_REGS, 8, number of 32-bit registers; legal range 2..2^(ADDR_W-2).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_awaddr  input  ADDR_W  write address.
- s_awvalid  input  1  write address valid.
- s_awready  output  1  write address ready.
- s_wdata  input  32  write data.
- s_wstrb  input  4  byte-lane write strobes.
- s_wvalid  input  1  write data valid.
- s_wready  output  1  write data ready.
- s_bresp  output  2  write response: 00 OKAY, 10 SLVERR.
- s_bvalid  output  1  write response valid.
- s_bready  input  1  write response ready.
- s_araddr  input  ADDR_W  read address.
- s_arvalid  input  1  read address valid.
- s_arready  output  1  read address ready.
- s_rdata  output  32  read data.
- s_rresp  output  2  read response: 00 OKAY, 10 SLVERR.
- s_rvalid  output  1  read data valid.
- s_rready  input  1  read data ready.
- status_in  input  32  live value returned when reading index NUM_REGS-1.
- ctrl_out  output  32  current contents of register 0.

Behaviour:
- Reset (asynchronous, active-high):
  - all registers = 0.
  - s_bvalid = s_rvalid = 0.
  - s_awready = s_wready = s_arready = 1.
  - s_bresp = s_rresp = 00; s_rdata = 0; ctrl_out = 0.
  - Any in-flight transaction is dropped. No response is issued for it after reset deasserts.
- Address decode:
  - idx = addr[ADDR_W-1:2]; addr[1:0] are ignored.
  - idx >= NUM_REGS -> SLVERR.
- Write path (two independent capture flags, aw_full and w_full):
  - s_awready = !aw_full && !s_bvalid.
  - s_wready = !w_full && !s_bvalid.
  - An AW or W handshake latches the address or data+strb and sets its flag. AW and W may arrive in either order or in the same cycle.
  - On the first edge where both flags are set, the write commits and s_bvalid=1 on that same edge; both flags clear.
  - Latency: the edge after the later of the two handshakes.
  - Commit with idx < NUM_REGS-1: byte lane i is updated only when wstrb[i]=1; bresp=00.
  - Commit with idx = NUM_REGS-1 or idx out of range: no state change; bresp=10.
  - s_bvalid and s_bresp hold until the s_bready handshake. No new AW/W is accepted while s_bvalid=1.
- Read path:
  - s_arready = !s_rvalid.
  - On the AR handshake edge: s_rvalid=1, and s_rdata/s_rresp are loaded in the same edge.
    - Register value for idx < NUM_REGS-1.
    - Sampled status_in for idx = NUM_REGS-1.
    - 0 with SLVERR for out of range.
  - s_rdata and s_rresp are stable while s_rvalid=1 && !s_rready. s_rvalid clears on the s_rready handshake.
  - Back-to-back reads are one every 2 cycles; there is no read pipelining.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the pre-write value.
  - A B handshake and a new AW on the same edge: the AW is not accepted that cycle (awready was 0).
- ctrl_out: register-driven, equal to register 0. It updates on the commit edge.
- Read and write paths are fully independent. Neither stalls the other.

Test Plan:
- Reset, then AW(0x000) and W(0xDEADBEEF, strb=F) in the same cycle, bready=1 -> bvalid 1 cycle later with bresp=00; ctrl_out=0xDEADBEEF; read 0x000 returns 0xDEADBEEF with OKAY.
- W(0x11223344) two cycles before AW(0x004), strb=0101 over an initial value of 0 -> reg1=0x00220044; bvalid on the edge after the AW handshake.
- Write to 0x01C (status, NUM_REGS=8) -> bresp=10 and register unchanged. Read 0x01C with status_in=0xA5A5_0001 -> rdata=0xA5A5_0001, OKAY. Read 0x020 -> rdata=0, rresp=10.
- bready held low for 5 cycles -> bvalid/bresp stable; awready=wready=0 throughout. rready held low for 5 cycles -> rdata stable and arready=0.
- Read of 0x008 on the same edge that a write of 0x55 to 0x008 commits, over an old value of 0x0 -> rdata=0x0; a following read -> 0x55.
- Assert reset while aw_full=1 and rvalid=1 -> all outputs return to reset values immediately; no bvalid or rvalid appears after release.
